// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - sequential initiator that drives a combinational alu and returns its result
module alu_issuer #(
    parameter int N      = 32,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  logic [2:0]   req_ctrl,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_ctrl,
    input  logic [N-1:0] alu_r,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_r,
    output logic         rsp_zero,
    output logic         rsp_illegal
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       ill_op;

    assign ill_op = (alu_ctrl == 3'b011) | (alu_ctrl == 3'b100) | (alu_ctrl == 3'b101);

    // Ready depends on rsp_ready only, so a waiting request never forms a loop with req_valid.
    assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= 3'b000;
            rsp_valid   <= 1'b0;
            rsp_r       <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_a    <= req_a;
                        alu_b    <= req_b;
                        alu_ctrl <= req_ctrl;
                        cnt      <= CNT_INIT;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == 4'd0) begin
                        rsp_r       <= alu_r;
                        rsp_zero    <= alu_zero;
                        rsp_illegal <= ill_op;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (req_valid) begin
                            alu_a    <= req_a;
                            alu_b    <= req_b;
                            alu_ctrl <= req_ctrl;
                            cnt      <= CNT_INIT;
                            state    <= DRIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issuer.sv
// tb/tb_alu_issuer.sv - self-checking bench for alu_issuer at SETTLE 1, 3 and 4
module tb_alu_issuer;
    localparam int N  = 32;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         req_valid[ND], req_ready[ND], rsp_valid[ND], rsp_ready[ND];
    logic         rsp_zero[ND], rsp_illegal[ND], alu_zero[ND];
    logic [N-1:0] req_a[ND], req_b[ND], alu_a[ND], alu_b[ND], alu_r[ND], rsp_r[ND];
    logic [2:0]   req_ctrl[ND], alu_ctrl[ND];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 0;

    function automatic int settle_of(int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    // Reference ALU: codes without a defined meaning still return something deterministic.
    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_alu
        assign alu_r[g]    = alu_f(alu_a[g], alu_b[g], alu_ctrl[g]);
        assign alu_zero[g] = (alu_r[g] == '0);
    end

    alu_issuer #(.N(N), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_ctrl(req_ctrl[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_ctrl(alu_ctrl[0]),
        .alu_r(alu_r[0]), .alu_zero(alu_zero[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_r(rsp_r[0]), .rsp_zero(rsp_zero[0]),
        .rsp_illegal(rsp_illegal[0]));

    alu_issuer #(.N(N), .SETTLE(3)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_ctrl(req_ctrl[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_ctrl(alu_ctrl[1]),
        .alu_r(alu_r[1]), .alu_zero(alu_zero[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_r(rsp_r[1]), .rsp_zero(rsp_zero[1]),
        .rsp_illegal(rsp_illegal[1]));

    alu_issuer #(.N(N), .SETTLE(4)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_a(req_a[2]), .req_b(req_b[2]), .req_ctrl(req_ctrl[2]),
        .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_ctrl(alu_ctrl[2]),
        .alu_r(alu_r[2]), .alu_zero(alu_zero[2]), .rsp_valid(rsp_valid[2]),
        .rsp_ready(rsp_ready[2]), .rsp_r(rsp_r[2]), .rsp_zero(rsp_zero[2]),
        .rsp_illegal(rsp_illegal[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: an accepted op answers exactly SETTLE edges later and
    // is held until consumed; everything else keeps its last value.
    bit          m_busy[ND];
    int          m_age[ND];
    logic [31:0] m_a[ND], m_b[ND], m_r[ND], m_pr[ND];
    logic [2:0]  m_c[ND];
    logic        m_z[ND], m_il[ND], m_pz[ND], m_pil[ND];

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_busy[d] = 0; m_age[d] = 0;
            m_a[d] = 0; m_b[d] = 0; m_c[d] = 0;
            m_r[d] = 0; m_z[d] = 0; m_il[d] = 0;
            m_pr[d] = 0; m_pz[d] = 0; m_pil[d] = 0;
        end
    endtask

    function automatic bit exp_valid(int d);
        return m_busy[d] && (m_age[d] >= settle_of(d));
    endfunction

    function automatic bit exp_ready(int d);
        return !m_busy[d] || (exp_valid(d) && rsp_ready[d]);
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                for (int d = 0; d < ND; d++) begin
                    bit rdy;
                    bit consumed;
                    rdy      = exp_ready(d);
                    consumed = exp_valid(d) && rsp_ready[d];
                    if (consumed) m_busy[d] = 0;
                    if (req_valid[d] && rdy) begin
                        m_busy[d] = 1; m_age[d] = 0;
                        m_a[d] = req_a[d]; m_b[d] = req_b[d]; m_c[d] = req_ctrl[d];
                        m_pr[d]  = alu_f(req_a[d], req_b[d], req_ctrl[d]);
                        m_pz[d]  = (m_pr[d] == 0);
                        m_pil[d] = (req_ctrl[d] inside {3'b011, 3'b100, 3'b101});
                    end else if (m_busy[d] && m_age[d] < settle_of(d)) begin
                        m_age[d]++;
                        if (m_age[d] == settle_of(d)) begin
                            m_r[d] = m_pr[d]; m_z[d] = m_pz[d]; m_il[d] = m_pil[d];
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < ND; d++) begin
                    chk($sformatf("req_ready[%0d]", d), 64'(req_ready[d]), 64'(exp_ready(d)));
                    chk($sformatf("rsp_valid[%0d]", d), 64'(rsp_valid[d]), 64'(exp_valid(d)));
                    chk($sformatf("alu_a[%0d]", d), 64'(alu_a[d]), 64'(m_a[d]));
                    chk($sformatf("alu_b[%0d]", d), 64'(alu_b[d]), 64'(m_b[d]));
                    chk($sformatf("alu_ctrl[%0d]", d), 64'(alu_ctrl[d]), 64'(m_c[d]));
                    chk($sformatf("rsp_r[%0d]", d), 64'(rsp_r[d]), 64'(m_r[d]));
                    chk($sformatf("rsp_zero[%0d]", d), 64'(rsp_zero[d]), 64'(m_z[d]));
                    chk($sformatf("rsp_illegal[%0d]", d), 64'(rsp_illegal[d]), 64'(m_il[d]));
                end
            end
        end
    end

    // One op on instance d; while the response waits, offer a competing request for `hold` cycles.
    task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input int hold,
                         output logic [31:0] r, output logic z, output logic il,
                         output logic [2:0] seen_ctrl, output int lat);
        @(posedge clk); #1;
        req_valid[d] = 1; req_a[d] = a; req_b[d] = b; req_ctrl[d] = c; rsp_ready[d] = 0;
        @(posedge clk); #1;
        req_valid[d] = 0;
        seen_ctrl = alu_ctrl[d];
        lat = 0;
        while (!rsp_valid[d] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        r = rsp_r[d]; z = rsp_zero[d]; il = rsp_illegal[d];
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = 1; req_a[d] = ~a; req_b[d] = ~b; req_ctrl[d] = 3'b001;
            #3;
            chk("bp_req_ready", 64'(req_ready[d]), 64'd0);
            @(posedge clk); #1;
            chk("bp_rsp_valid", 64'(rsp_valid[d]), 64'd1);
            chk("bp_rsp_r", 64'(rsp_r[d]), 64'(r));
            chk("bp_rsp_flags", 64'({rsp_zero[d], rsp_illegal[d]}), 64'({z, il}));
            chk("bp_alu_a", 64'(alu_a[d]), 64'(a));
        end
        req_valid[d] = 0; rsp_ready[d] = 1;
        @(posedge clk); #1;
        rsp_ready[d] = 0;
    endtask

    logic [31:0] r;
    logic        z, il;
    logic [2:0]  sc;
    int          lat;
    logic [31:0] got[4];
    int          tcy[4];
    int          nresp, idx;
    bit          acc, seen;

    initial begin
        rst_n = 0;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 0; rsp_ready[d] = 0;
            req_a[d] = 0; req_b[d] = 0; req_ctrl[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_n  = 1;
        chk_en = 1;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("reset_req_ready", 64'(req_ready[d]), 64'd1);
            chk("reset_rsp_valid", 64'(rsp_valid[d]), 64'd0);
            chk("reset_alu", 64'({alu_a[d], alu_ctrl[d]}), 64'd0);
            chk("reset_rsp", 64'({rsp_r[d], rsp_zero[d], rsp_illegal[d]}), 64'd0);
        end

        do_op(0, 32'hAA, 32'hCC, 3'b000, 0, r, z, il, sc, lat);
        chk("and_r", 64'(r), 64'h88);
        chk("and_flags", 64'({z, il}), 64'd0);
        chk("and_latency", 64'(lat), 64'd1);
        do_op(0, 32'hAA, 32'hCC, 3'b010, 0, r, z, il, sc, lat);
        chk("add_r", 64'(r), 64'h176);
        chk("add_latency", 64'(lat), 64'd1);
        do_op(0, 32'd5, 32'd5, 3'b110, 0, r, z, il, sc, lat);
        chk("sub_r", 64'(r), 64'd0);
        chk("sub_zero", 64'(z), 64'd1);
        do_op(0, 32'd3, 32'd7, 3'b111, 0, r, z, il, sc, lat);
        chk("slt_r", 64'(r), 64'd1);
        chk("slt_zero", 64'(z), 64'd0);
        do_op(0, 32'hFFFF_FFFF, 32'd1, 3'b011, 0, r, z, il, sc, lat);
        chk("illegal_alu_ctrl", 64'(sc), 64'd3);
        chk("illegal_flag", 64'(il), 64'd1);
        chk("illegal_r", 64'(r), 64'hFFFF_FFFE);

        do_op(1, 32'd10, 32'd4, 3'b110, 5, r, z, il, sc, lat);
        chk("bp_latency", 64'(lat), 64'd3);
        chk("bp_r", 64'(r), 64'd6);

        // Back-to-back ADDs with both valids held high.
        @(posedge clk); #1;
        idx = 1; nresp = 0;
        req_valid[0] = 1; rsp_ready[0] = 1;
        req_a[0] = 1; req_b[0] = 1; req_ctrl[0] = 3'b010;
        for (int t = 0; t < 40 && nresp < 4; t++) begin
            @(negedge clk);
            acc = req_valid[0] && req_ready[0];
            if (rsp_valid[0]) begin
                got[nresp] = rsp_r[0]; tcy[nresp] = cyc; nresp++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx > 4) req_valid[0] = 0;
                else begin req_a[0] = idx; req_b[0] = idx; end
            end
        end
        req_valid[0] = 0; rsp_ready[0] = 0;
        chk("b2b_count", 64'(nresp), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_value", 64'(got[i]), 64'(2 * (i + 1)));
            if (i > 0) chk("b2b_spacing", 64'(tcy[i] - tcy[i-1]), 64'd2);
        end

        // Randomised traffic on all three instances.
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            for (int d = 0; d < ND; d++) begin
                req_valid[d] = 1'($urandom_range(0, 1));
                rsp_ready[d] = ($urandom_range(0, 3) != 0);
                req_a[d]     = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
                req_b[d]     = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
                req_ctrl[d]  = 3'($urandom_range(0, 7));
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) begin req_valid[d] = 0; rsp_ready[d] = 1; end
        repeat (8) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) rsp_ready[d] = 0;

        // Reset while instance 2 (SETTLE=4) is still driving.
        @(posedge clk); #1;
        req_valid[2] = 1; req_a[2] = 32'h1234; req_b[2] = 32'h10; req_ctrl[2] = 3'b001;
        @(posedge clk); #1;
        req_valid[2] = 0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_reset_alu_a", 64'(alu_a[2]), 64'h1234);
        #2;
        rst_n = 0;
        #1;
        chk("mid_reset_alu", 64'({alu_a[2], alu_b[2], alu_ctrl[2]}), 64'd0);
        chk("mid_reset_rsp", 64'({rsp_valid[2], rsp_r[2], rsp_zero[2], rsp_illegal[2]}), 64'd0);
        chk("mid_reset_req_ready", 64'(req_ready[2]), 64'd1);
        @(negedge clk); #2;
        rst_n = 1;
        seen = 0;
        rsp_ready[2] = 1;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (rsp_valid[2]) seen = 1;
        end
        rsp_ready[2] = 0;
        chk("no_rsp_after_reset", 64'(seen), 64'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
